// File: rtl/instr_exec_seq.sv
// Fetch/execute sequencer downstream of the instruction register: walks an address
// range, executes each instruction and streams results out in address order.
package instr_register_pkg;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [4:0]         address_t;
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  res;
  } instruction_t;
endpackage

module instr_exec_seq
  import instr_register_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [4:0]                        start_addr,
  input  logic [5:0]                        count,
  output logic [4:0]                        read_pointer,
  input  logic [$bits(instruction_t)-1:0]   instruction_word,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic signed [63:0]                res_data,
  output logic [3:0]                        res_opc,
  output logic [4:0]                        res_addr,
  output logic                              res_dbz,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    DIVIDE = 3'd3,
    OUTPUT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_next;

  instruction_t iw;
  logic         unused_res;

  logic [3:0]  opc_q;
  operand_t    op_a_q;
  operand_t    op_b_q;
  logic [5:0]  remaining;

  result_t     a64, b64;
  result_t     exec_res;
  logic        exec_dbz;
  logic        div_go;

  logic [31:0] ua, ub, mag_a, mag_b;
  logic [31:0] quo, rem, dvs;
  logic        q_neg, r_neg, is_mod;
  logic [CW-1:0] div_cnt;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff, quo_n, rem_n;
  logic [63:0] q64, r64, div_res;

  assign iw         = instruction_t'(instruction_word);
  assign unused_res = ^iw.res;

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (count == '0) ? DONE : FETCH;
      end
      FETCH:  state_next = EXEC;
      EXEC:   state_next = div_go ? DIVIDE : OUTPUT;
      DIVIDE: if (div_cnt == CW'(1)) state_next = OUTPUT;
      OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = (remaining == 6'd1) ? DONE : FETCH;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- single-cycle execute ----------------
  assign a64 = {{32{op_a_q[31]}}, op_a_q};
  assign b64 = {{32{op_b_q[31]}}, op_b_q};

  always_comb begin
    exec_res = '0;
    exec_dbz = 1'b0;
    div_go   = 1'b0;
    case (opc_q)
      ZERO:     exec_res = '0;
      PASSA:    exec_res = a64;
      PASSB:    exec_res = b64;
      ADD:      exec_res = a64 + b64;
      SUB:      exec_res = a64 - b64;
      MULT:     exec_res = a64 * b64;
      DIV, MOD: begin
        if (op_b_q == '0) exec_dbz = 1'b1;
        else              div_go   = 1'b1;
      end
      default:  exec_res = '0;
    endcase
  end

  // ---------------- restoring divider step ----------------
  assign ua    = op_a_q;
  assign ub    = op_b_q;
  assign mag_a = ua[31] ? (~ua + 32'd1) : ua;
  assign mag_b = ub[31] ? (~ub + 32'd1) : ub;

  // Remainder stays below the divisor (<= 2^31), so 32 bits plus the shifted-in bit suffice.
  assign shifted = {rem, quo[31]};
  assign fits    = (shifted >= {1'b0, dvs});
  assign diff    = shifted[31:0] - dvs;
  assign rem_n   = fits ? diff : shifted[31:0];
  assign quo_n   = {quo[30:0], fits};

  assign q64     = {32'd0, quo_n};
  assign r64     = {32'd0, rem_n};
  assign div_res = is_mod ? (r_neg ? neg64(r64) : r64)
                          : (q_neg ? neg64(q64) : q64);

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      read_pointer <= '0;
      remaining    <= '0;
      opc_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      res_data     <= '0;
      res_opc      <= '0;
      res_addr     <= '0;
      res_dbz      <= 1'b0;
      quo          <= '0;
      rem          <= '0;
      dvs          <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      is_mod       <= 1'b0;
      div_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && count != '0) begin
            read_pointer <= start_addr;
            remaining    <= count;
          end
        end
        FETCH: begin
          opc_q  <= iw.opc;
          op_a_q <= iw.op_a;
          op_b_q <= iw.op_b;
        end
        EXEC: begin
          if (div_go) begin
            quo     <= mag_a;
            rem     <= '0;
            dvs     <= mag_b;
            q_neg   <= op_a_q[31] ^ op_b_q[31];
            r_neg   <= op_a_q[31];
            is_mod  <= (opc_q == MOD);
            div_cnt <= CW'(DIV_CYCLES);
          end else begin
            res_data <= exec_res;
            res_opc  <= opc_q;
            res_addr <= read_pointer;
            res_dbz  <= exec_dbz;
          end
        end
        DIVIDE: begin
          quo     <= quo_n;
          rem     <= rem_n;
          div_cnt <= div_cnt - CW'(1);
          if (div_cnt == CW'(1)) begin
            res_data <= div_res;
            res_opc  <= opc_q;
            res_addr <= read_pointer;
            res_dbz  <= 1'b0;
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            read_pointer <= read_pointer + 5'd1;
            remaining    <= remaining - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
